// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Request/response front end for the 256 x 65-bit data memory. Accepts one
// load/store at a time from the CPU datapath over a valid/ready handshake.
// It checks alignment and range, drives the memory port for one cycle, and
// registers the memory's combinational read data into a held response. It
// also keeps saturating access statistics.
//
// Parameters
//   ADDR_W     request / memory address width
//   DATA_W     data width
//   WORDS_LOG2 log2 of memory depth (memory indexes address[WORDS_LOG2:1])
//   CNT_W      width of each statistics counter
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_we              1 = store, 0 = load
//   req_addr            byte-style address, bit 0 must be 0
//   req_wdata           store data
//   resp_valid/ready    response handshake
//   resp_data           load data (0 for stores and rejected requests)
//   resp_err            request rejected (misaligned or out of range)
//   mem_*               memory address / write data / write enable /
//                       read enable / combinational read data
//   cnt_reads           completed good loads
//   cnt_writes          completed good stores
//   cnt_errors          rejected requests
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W     = 65,
    parameter int DATA_W     = 65,
    parameter int WORDS_LOG2 = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data,

    output logic [CNT_W-1:0]  cnt_reads,
    output logic [CNT_W-1:0]  cnt_writes,
    output logic [CNT_W-1:0]  cnt_errors
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Handshake events decoded by the FSM
    logic accept;
    logic finish;

    // Latched request (stage p0) and held response (stage p1)
    logic              we_p0;
    logic              err_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic [DATA_W-1:0] resp_data_p1;
    logic              resp_err_p1;

    logic [CNT_W-1:0]  cnt_reads_q;
    logic [CNT_W-1:0]  cnt_writes_q;
    logic [CNT_W-1:0]  cnt_errors_q;

    // A request is rejected when it is odd or addresses above the top word.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return a[0] | (|a[ADDR_W-1:WORDS_LOG2+1]);
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. Memory-side outputs depend on state
    // only, so a store in ACCESS still commits on a reset edge.
    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        accept         = 1'b0;
        finish         = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end

            ACCESS: begin
                mem_address    = addr_p0;
                mem_write_data = wdata_p0;
                // A rejected request never touches the memory.
                mem_write_en   = ~err_p0 &  we_p0;
                mem_read_en    = ~err_p0 & ~we_p0;
                finish         = 1'b1;
                state_next     = RESP;
            end

            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---- stage p0: request latch ----
    always_ff @(posedge clk) begin
        if (reset) begin
            we_p0    <= 1'b0;
            err_p0   <= 1'b0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
        end else if (accept) begin
            we_p0    <= req_we;
            err_p0   <= addr_err(req_addr);
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    // ---- stage p1: response capture at the end of ACCESS ----
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_data_p1 <= '0;
            resp_err_p1  <= 1'b0;
        end else if (finish) begin
            resp_data_p1 <= (!err_p0 && !we_p0) ? mem_read_data : '0;
            resp_err_p1  <= err_p0;
        end
    end

    // Exactly one counter moves per completed request; errors take priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reads_q  <= '0;
            cnt_writes_q <= '0;
            cnt_errors_q <= '0;
        end else if (finish) begin
            if (err_p0) begin
                cnt_errors_q <= sat_inc(cnt_errors_q);
            end else if (we_p0) begin
                cnt_writes_q <= sat_inc(cnt_writes_q);
            end else begin
                cnt_reads_q  <= sat_inc(cnt_reads_q);
            end
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_data  = resp_data_p1;
    assign resp_err   = resp_err_p1;

    assign cnt_reads  = cnt_reads_q;
    assign cnt_writes = cnt_writes_q;
    assign cnt_errors = cnt_errors_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl. A behavioural 256 x 65-bit memory with
// combinational read and clocked write sits on the memory port. A second
// instance with 2-bit counters shares the same stimulus so that counter
// saturation can be reached in a handful of requests.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int ADDR_W = 65;
    localparam int DATA_W = 65;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic              mem_read_en;
    logic [DATA_W-1:0] mem_read_data;
    logic [CNT_W-1:0]  cnt_reads;
    logic [CNT_W-1:0]  cnt_writes;
    logic [CNT_W-1:0]  cnt_errors;

    // Small-counter instance outputs
    logic              s_req_ready;
    logic              s_resp_valid;
    logic [DATA_W-1:0] s_resp_data;
    logic              s_resp_err;
    logic [ADDR_W-1:0] s_mem_address;
    logic [DATA_W-1:0] s_mem_write_data;
    logic              s_mem_write_en;
    logic              s_mem_read_en;
    logic [1:0]        s_cnt_reads;
    logic [1:0]        s_cnt_writes;
    logic [1:0]        s_cnt_errors;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic last_rd_en;
    logic last_wr_en;
    logic [DATA_W-1:0] rdata;
    logic              rerr;

    localparam logic [DATA_W-1:0] D1 = 65'h0_0000_0001_2345_6789;
    localparam logic [DATA_W-1:0] DA = 65'h1_DEAD_BEEF_0000_0001;
    localparam logic [DATA_W-1:0] DZ = 65'h0_5A5A_5A5A_5A5A_5A5A;
    localparam logic [DATA_W-1:0] D2 = 65'h1_0000_0000_0000_00FF;
    localparam logic [DATA_W-1:0] D3 = 65'h0_0000_0000_CAFE_F00D;
    localparam logic [DATA_W-1:0] DX = 65'h0_1111_2222_3333_4444;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_LOG2(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data),
        .cnt_reads(cnt_reads), .cnt_writes(cnt_writes), .cnt_errors(cnt_errors)
    );

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_LOG2(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready),
        .resp_data(s_resp_data), .resp_err(s_resp_err),
        .mem_address(s_mem_address), .mem_write_data(s_mem_write_data),
        .mem_write_en(s_mem_write_en), .mem_read_en(s_mem_read_en),
        .mem_read_data(mem_read_data),
        .cnt_reads(s_cnt_reads), .cnt_writes(s_cnt_writes), .cnt_errors(s_cnt_errors)
    );

    // Behavioural data memory: combinational read, write on rising edge.
    logic [DATA_W-1:0] mem [256];
    assign mem_read_data = mem[mem_address[8:1]];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_address[8:1]] <= mem_write_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full request/response transaction with the fixed 3-cycle timing.
    task automatic do_req(input logic we, input logic [64:0] addr, input logic [64:0] wdata,
                          output logic [64:0] rd, output logic re);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        last_rd_en = mem_read_en;
        last_wr_en = mem_write_en;
        check("resp_valid_in_access", resp_valid, 0);
        @(negedge clk);
        check("resp_valid_in_resp", resp_valid, 1);
        rd = resp_data;
        re = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // T1: reset then idle
        @(posedge clk);
        @(negedge clk);
        check("t1_we_in_reset", mem_write_en, 0);
        check("t1_re_in_reset", mem_read_en, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t1_req_ready", req_ready, 1);
        check("t1_resp_valid", resp_valid, 0);
        check("t1_we", mem_write_en, 0);
        check("t1_re", mem_read_en, 0);
        check("t1_cnt_rd", cnt_reads, 0);
        check("t1_cnt_wr", cnt_writes, 0);
        check("t1_cnt_err", cnt_errors, 0);
        check("t1_resp_data", resp_data, 0);

        // T2: store then load word 2
        do_req(1'b1, 65'h004, D1, rdata, rerr);
        check("t2_st_err", rerr, 0);
        check("t2_st_data", rdata, 0);
        check("t2_st_wr_en", last_wr_en, 1);
        check("t2_st_rd_en", last_rd_en, 0);
        do_req(1'b0, 65'h004, '0, rdata, rerr);
        check("t2_ld_err", rerr, 0);
        check("t2_ld_data", rdata, D1);
        check("t2_ld_rd_en", last_rd_en, 1);
        check("t2_cnt_wr", cnt_writes, 1);
        check("t2_cnt_rd", cnt_reads, 1);

        // T4: misaligned load
        do_req(1'b0, 65'h005, '0, rdata, rerr);
        check("t4_err", rerr, 1);
        check("t4_data", rdata, 0);
        check("t4_rd_en", last_rd_en, 0);
        check("t4_cnt_err", cnt_errors, 1);
        check("t4_cnt_rd", cnt_reads, 1);

        // T3: top word, then an out-of-range store aliasing word 0
        do_req(1'b1, 65'h1FE, DA, rdata, rerr);
        check("t3_st_top_err", rerr, 0);
        do_req(1'b0, 65'h1FE, '0, rdata, rerr);
        check("t3_ld_top_data", rdata, DA);
        do_req(1'b1, 65'h000, DZ, rdata, rerr);
        check("t3_st0_err", rerr, 0);
        do_req(1'b1, 65'h200, DX, rdata, rerr);
        check("t3_st200_err", rerr, 1);
        check("t3_st200_wr_en", last_wr_en, 0);
        do_req(1'b1, 65'h1_0000_0000_0000_0004, DX, rdata, rerr);
        check("t3_st_hibit_err", rerr, 1);
        do_req(1'b0, 65'h000, '0, rdata, rerr);
        check("t3_ld0_data", rdata, DZ);
        check("t3_cnt_wr", cnt_writes, 3);
        check("t3_cnt_rd", cnt_reads, 3);
        check("t3_cnt_err", cnt_errors, 3);

        // Counter saturation on the 2-bit instance
        do_req(1'b1, 65'h010, DX, rdata, rerr);
        check("sat_main_wr", cnt_writes, 4);
        check("sat_small_wr", s_cnt_writes, 3);
        check("sat_small_rd", s_cnt_reads, 3);
        check("sat_small_err", s_cnt_errors, 3);
        do_req(1'b0, 65'h007, '0, rdata, rerr);
        check("sat_main_err", cnt_errors, 4);
        check("sat_small_err2", s_cnt_errors, 3);

        // T5: response held for 10 cycles with a new request waiting
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 65'h004;
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_addr  = 65'h008;
        req_wdata = D2;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_valid", resp_valid, 1);
            check("t5_hold_data", resp_data, D1);
            check("t5_hold_ready", req_ready, 0);
            @(negedge clk);
        end
        check("t5_cnt_wr_hold", cnt_writes, 4);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("t5_ready_after", req_ready, 1);
        check("t5_valid_after", resp_valid, 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("t5_st_wr_en", mem_write_en, 1);
        @(negedge clk);
        check("t5_st_valid", resp_valid, 1);
        check("t5_st_err", resp_err, 0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        do_req(1'b0, 65'h008, '0, rdata, rerr);
        check("t5_ld_data", rdata, D2);
        check("t5_cnt_wr", cnt_writes, 5);
        check("t5_cnt_rd", cnt_reads, 5);

        // T6a: reset while a response is pending
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 65'h004;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_pre_valid", resp_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_valid", resp_valid, 0);
        check("t6_ready", req_ready, 1);
        check("t6_cnt_rd", cnt_reads, 0);
        check("t6_cnt_wr", cnt_writes, 0);
        check("t6_cnt_err", cnt_errors, 0);
        check("t6_resp_data", resp_data, 0);

        // T6b: reset coinciding with a store's ACCESS cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 65'h020;
        req_wdata = D3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("t6b_wr_en", mem_write_en, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6b_valid", resp_valid, 0);
        check("t6b_cnt_wr", cnt_writes, 0);
        do_req(1'b0, 65'h020, '0, rdata, rerr);
        check("t6b_ld_data", rdata, D3);
        check("t6b_ld_err", rerr, 0);
        check("t6b_cnt_rd", cnt_reads, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
